// File: rtl/fetch_ctrl.sv
// Program counter and Start/Done sequencing for the instruction ROM of the 9-bit core.
// Latency: PrgCtr/Done/Overrun/InstCnt update one cycle after the request; Fetch follows state combinationally.
// Backpressure: Stall holds PrgCtr and InstCnt in RUN; a branch presented together with Stall is dropped.
module fetch_ctrl #(
  parameter int             D          = 12,
  parameter logic [D-1:0]   START_ADDR = '0,
  parameter int             CW         = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [D-1:0]  Target,
  input  logic          Halt,
  output logic [D-1:0]  PrgCtr,
  output logic          Fetch,
  output logic          Done,
  output logic          Overrun,
  output logic [CW-1:0] InstCnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [D-1:0]  pc_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          ovr_nxt;
  logic          done_nxt;

  // Saturating increment: a retired instruction never wraps the counter back to zero.
  logic [CW-1:0] cnt_inc;
  assign cnt_inc = (InstCnt == '1) ? InstCnt : InstCnt + 1'b1;

  // Last ROM word: a plain sequential step from here runs off the end of the program.
  logic          pc_at_end;
  assign pc_at_end = (PrgCtr == '1);

  // Relative branch target; the D-bit sum wraps naturally in both directions.
  logic [D-1:0]  pc_rel;
  assign pc_rel = PrgCtr + Target;

  // ROM output is only meaningful while the program is running.
  assign Fetch = (state == ST_RUN);

  // Next-state and next-register values; every path starts from "hold everything".
  always_comb begin
    state_nxt = state;
    pc_nxt    = PrgCtr;
    cnt_nxt   = InstCnt;
    ovr_nxt   = Overrun;
    unique case (state)
      ST_IDLE: begin
        if (Start) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // Stay armed while Start is held; the first fetch is the cycle after it drops.
        if (!Start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Exactly one action per cycle, in priority order halt > stall > branch > step.
        if (Halt) begin
          state_nxt = ST_DONE;
          cnt_nxt   = cnt_inc;
        end else if (Stall) begin
          // Hold; any branch request this cycle is discarded and must be re-presented.
        end else if (BranchEn) begin
          pc_nxt  = BranchRel ? pc_rel : Target;
          cnt_nxt = cnt_inc;
        end else if (!pc_at_end) begin
          pc_nxt  = PrgCtr + 1'b1;
          cnt_nxt = cnt_inc;
        end else begin
          // Fell off the last word without a halt: stop here rather than wrap to 0.
          state_nxt = ST_DONE;
          ovr_nxt   = 1'b1;
          cnt_nxt   = cnt_inc;
        end
      end
      ST_DONE: begin
        if (Start) begin
          state_nxt = ST_ARMED;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Entering or sitting in ARMED reloads the program context.
    if (state_nxt == ST_ARMED) begin
      pc_nxt  = START_ADDR;
      cnt_nxt = '0;
      ovr_nxt = 1'b0;
    end

    done_nxt = (state_nxt == ST_DONE);
  end

  // State and output registers with synchronous reset back to IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= ST_IDLE;
      PrgCtr  <= START_ADDR;
      Done    <= 1'b0;
      Overrun <= 1'b0;
      InstCnt <= '0;
    end else begin
      state   <= state_nxt;
      PrgCtr  <= pc_nxt;
      Done    <= done_nxt;
      Overrun <= ovr_nxt;
      InstCnt <= cnt_nxt;
    end
  end

endmodule
